// File: rtl/boot_loader_pkg.sv
// boot_pkg: shared loader state encoding and datapath widths.
package boot_pkg;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int LEN_BYTES = 2;
   typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR} boot_state_t;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: upstream byte stream plus instruction-memory write port.
interface boot_loader_if;
   import boot_pkg::*;
   logic              byte_valid;
   logic [BYTE_W-1:0] byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [WORD_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;
   modport master (output byte_valid, byte_data, input byte_ready, imem_we, imem_addr, imem_wdata);
   modport slave  (input byte_valid, byte_data, output byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/boot_loader_packer.sv
// word_packer: shifts accepted bytes into a little-endian word, flags the 4th byte.
module word_packer
   import boot_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [BYTE_W-1:0] din,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);
   logic [1:0] cnt;
   assign word_full = en && cnt == 2'd3;
   always_ff @(posedge clk)
      if (reset) begin
         cnt  <= '0;
         word <= '0;
      end else if (en) begin
         cnt  <= cnt + 2'd1;
         word <= {din, word[WORD_W-1:BYTE_W]};
      end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: parses a length-prefixed byte stream into imem writes, verifies an
// XOR checksum, and releases the core from reset only on a clean load.
module boot_loader
   import boot_pkg::*;
#(
   parameter int          MEM_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic clk,
   input  logic reset,
   boot_loader_if.slave bus,
   output logic core_resetn,
   output logic done,
   output logic error
);
   boot_state_t       state, nxt;
   logic [15:0]       n_words, word_idx, n_cand;
   logic [BYTE_W-1:0] len_lo, csum;
   logic [WORD_W-1:0] pk_word;
   logic              xfer, full, we_q;
   assign bus.byte_ready = state inside {LEN_LO, LEN_HI, DATA, CHECK};
   assign xfer = bus.byte_valid && bus.byte_ready;
   assign n_cand = {bus.byte_data, len_lo};
   // a reset landing on the WRITE cycle must not let the strobe reach memory
   assign bus.imem_we = we_q && !reset;
   word_packer u_pack (
      .clk       (clk),
      .reset     (reset),
      .en        (xfer && state == DATA),
      .din       (bus.byte_data),
      .word      (pk_word),
      .word_full (full)
   );
   always_comb begin
      nxt = state;
      case (state)
         LEN_LO:  nxt = xfer ? LEN_HI : LEN_LO;
         LEN_HI:  nxt = !xfer ? LEN_HI : ({1'b0, n_cand} > 17'(MEM_WORDS)) ? ERROR : (n_cand == '0) ? CHECK : DATA;
         DATA:    nxt = full ? WRITE : DATA;
         WRITE:   nxt = (word_idx + 16'd1 == n_words) ? CHECK : DATA;
         CHECK:   nxt = !xfer ? CHECK : (bus.byte_data == csum) ? DONE : ERROR;
         default: nxt = state;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         state          <= LEN_LO;
         n_words        <= '0;
         word_idx       <= '0;
         len_lo         <= '0;
         csum           <= '0;
         we_q           <= 1'b0;
         bus.imem_addr  <= BASE_ADDR;
         bus.imem_wdata <= '0;
         core_resetn    <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         state <= nxt;
         we_q  <= full;
         if (state == LEN_LO && xfer) len_lo <= bus.byte_data;
         if (state == LEN_HI && xfer) n_words <= n_cand;
         if (state == DATA && xfer) csum <= csum ^ bus.byte_data;
         if (full) begin
            bus.imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            bus.imem_wdata <= {bus.byte_data, pk_word[WORD_W-1:BYTE_W]};
         end
         if (state == WRITE) word_idx <= word_idx + 16'd1;
         core_resetn <= nxt == DONE;
         done        <= nxt == DONE;
         error       <= nxt == ERROR;
      end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed streams checked against a stream-level model of the loader.
module tb_boot_loader;
   localparam int          MEMW = 256;
   localparam logic [31:0] BASE = 32'h0;
   typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
   typedef logic [7:0] bq_t[$];

   logic clk = 0, reset = 1, core_resetn, done, error;
   int   total = 0, passed = 0;
   wr_t  exp_q[$], wr_log[$];

   boot_loader_if bus();
   boot_loader #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .bus(bus), .core_resetn(core_resetn), .done(done), .error(error));

   always #5 clk = ~clk;

   function automatic void chk(bit ok, string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         chk(core_resetn == done, "resetn_vs_done", {31'd0, core_resetn}, {31'd0, done});
         chk(!(done && error), "done_and_error", {30'd0, done, error}, 32'd0);
         if (bus.imem_we) begin
            wr_t e;
            wr_log.push_back('{bus.imem_addr, bus.imem_wdata});
            chk(exp_q.size() > 0, "write_expected", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk(bus.imem_addr == e.a, "imem_addr", bus.imem_addr, e.a);
               chk(bus.imem_wdata == e.d, "imem_wdata", bus.imem_wdata, e.d);
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1;
      bus.byte_valid = 0;
      bus.byte_data = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      exp_q.delete();
      wr_log.delete();
      chk(bus.imem_we == 0, "rst_we", {31'd0, bus.imem_we}, 0);
      chk(core_resetn == 0, "rst_resetn", {31'd0, core_resetn}, 0);
      chk(done == 0 && error == 0, "rst_done_err", {30'd0, done, error}, 0);
      chk(bus.byte_ready == 1, "rst_ready", {31'd0, bus.byte_ready}, 1);
      chk(bus.imem_addr == BASE, "rst_addr", bus.imem_addr, BASE);
      chk(bus.imem_wdata == 0, "rst_wdata", bus.imem_wdata, 0);
   endtask

   task automatic send(input logic [7:0] b, input bit stall);
      int t;
      if (stall) repeat ($urandom_range(0, 3)) begin
         bus.byte_valid = 0;
         bus.byte_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      bus.byte_valid = 1;
      bus.byte_data = b;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.byte_ready && t < 50);
      if (!bus.byte_ready) begin
         chk(bus.byte_ready, "ready_timeout", t, 50);
         bus.byte_valid = 0;
         return;
      end
      @(posedge clk);
      #1 bus.byte_valid = 0;
   endtask

   task automatic run(input bq_t s, input bit stall);
      int n;
      logic [7:0] cs;
      bit exp_done;
      n = int'({s[1], s[0]});
      cs = 0;
      exp_done = 0;
      if (n <= MEMW) begin
         for (int i = 0; i < n; i++)
            exp_q.push_back('{BASE + 32'(4 * i), {s[5+4*i], s[4+4*i], s[3+4*i], s[2+4*i]}});
         for (int i = 2; i < 2 + 4 * n; i++) cs ^= s[i];
         exp_done = s[2+4*n] == cs;
      end
      for (int i = 0; i < s.size(); i++) begin
         send(s[i], stall);
         if (n <= MEMW && i >= 2 && i < 2 + 4 * n && (i - 2) % 4 == 3)
            chk(bus.imem_we == 1, "write_latency", {31'd0, bus.imem_we}, 1);
      end
      chk(core_resetn == exp_done, "resetn_timing", {31'd0, core_resetn}, {31'd0, exp_done});
      repeat (3) @(posedge clk);
      #1;
      chk(exp_q.size() == 0, "writes_outstanding", exp_q.size(), 0);
      chk(done == exp_done, "done", {31'd0, done}, {31'd0, exp_done});
      chk(error == !exp_done, "error", {31'd0, error}, {31'd0, !exp_done});
      chk(core_resetn == exp_done, "core_resetn", {31'd0, core_resetn}, {31'd0, exp_done});
      chk(bus.byte_ready == 0, "ready_final", {31'd0, bus.byte_ready}, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bq_t s;
      logic [7:0] x;
      do_reset();
      s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
      run(s, 0);
      chk(wr_log.size() == 1, "t1_count", wr_log.size(), 1);
      if (wr_log.size() > 0) chk(wr_log[0].d == 32'h00500093 && wr_log[0].a == 0, "t1_word", wr_log[0].d, 32'h00500093);
      chk(done == 1, "t1_done_lit", {31'd0, done}, 1);

      do_reset();
      s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h00};
      run(s, 0);
      chk(wr_log.size() == 1, "t2_count", wr_log.size(), 1);
      chk(error == 1 && core_resetn == 0, "t2_err_lit", {30'd0, error, core_resetn}, 32'd2);

      do_reset();
      s = '{8'h01, 8'h01};
      run(s, 0);
      chk(wr_log.size() == 0, "t3_no_writes", wr_log.size(), 0);
      chk(error == 1, "t3_err_lit", {31'd0, error}, 1);

      do_reset();
      s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h34, 8'h00, 8'h87};
      run(s, 1);
      chk(wr_log.size() == 2, "t4_count", wr_log.size(), 2);
      if (wr_log.size() == 2) begin
         chk(wr_log[0].a == 32'h0 && wr_log[0].d == 32'h00000513, "t4_w0", wr_log[0].d, 32'h00000513);
         chk(wr_log[1].a == 32'h4 && wr_log[1].d == 32'h003412B7, "t4_w1", wr_log[1].d, 32'h003412B7);
      end

      do_reset();
      s = '{8'h01, 8'h00, 8'h93, 8'h00};
      foreach (s[i]) send(s[i], 0);
      chk(wr_log.size() == 0, "t5_partial", wr_log.size(), 0);
      do_reset();
      s = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
      run(s, 0);
      chk(wr_log.size() == 1, "t5_count", wr_log.size(), 1);
      if (wr_log.size() > 0) chk(wr_log[0].d == 32'h00500093, "t5_word", wr_log[0].d, 32'h00500093);

      do_reset();
      s = '{8'h00, 8'h00, 8'h00};
      run(s, 0);
      chk(wr_log.size() == 0 && done == 1, "t6_empty_done", wr_log.size(), 0);

      do_reset();
      s = '{8'h00, 8'h01};
      x = 0;
      for (int i = 0; i < 4 * MEMW; i++) begin
         s.push_back(8'(i * 37 + 5));
         x ^= 8'(i * 37 + 5);
      end
      s.push_back(x);
      run(s, 0);
      chk(wr_log.size() == MEMW, "t7_count", wr_log.size(), MEMW);
      if (wr_log.size() == MEMW) chk(wr_log[MEMW-1].a == 32'h3FC, "t7_last_addr", wr_log[MEMW-1].a, 32'h3FC);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter MEM_WORDS, default 256, is the instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first loaded word.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 byte_valid  input  1  upstream byte stream valid.
REQ-006 byte_data  input  8  upstream byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of the word being written.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 core_resetn  output  1  active-low reset to the processor top (its resetn); low until load succeeds.
REQ-012 done  output  1  load complete and checksum good; sticky.
REQ-013 error  output  1  length overflow or checksum mismatch; sticky.

Function
REQ-014 A byte SHALL transfer only on a rising edge with byte_valid && byte_ready; byte_data is ignored otherwise.
REQ-015 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then 1 checksum byte.
REQ-016 FSM states SHALL be LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR; reset state LEN_LO.
REQ-017 byte_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 in WRITE, DONE and ERROR.
REQ-018 LEN_LO -> LEN_HI on transfer; LEN_HI -> ERROR if N > MEM_WORDS, -> CHECK if N == 0, else -> DATA.
REQ-019 Data bytes SHALL pack little-endian (first byte -> bits 7:0); the 4th transfer of a word moves the FSM to WRITE.
REQ-020 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=BASE_ADDR+4*word_idx and imem_wdata = the packed word; then word_idx increments, and the FSM enters CHECK if word_idx+1 == N, else DATA.
REQ-021 imem_we SHALL be 0 in every state other than WRITE; imem_addr and imem_wdata are don't-care when imem_we=0 but SHALL hold their last values.
REQ-022 The running checksum SHALL be the XOR of all data bytes, excluding length and checksum bytes.
REQ-023 CHECK -> DONE on a transfer equal to the running checksum, else -> ERROR.
REQ-024 DONE SHALL drive done=1 and core_resetn=1 until reset; ERROR SHALL drive error=1 and core_resetn=0 until reset.
REQ-025 core_resetn, done and error SHALL be registered outputs, and core_resetn SHALL rise the cycle after the checksum transfer.
REQ-026 Latency: the imem write SHALL occur the cycle after the 4th byte of a word is accepted; peak throughput is 4 bytes per 5 cycles.
REQ-027 Stalls (byte_valid=0) of any length SHALL leave the FSM, partial word, word_idx and checksum unchanged.
REQ-028 word_idx SHALL be 16 bits wide and never exceed MEM_WORDS-1 when imem_we=1, with no wrap-around.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL enter LEN_LO and clear word_idx, N, the byte counter, the partial word and the checksum.
REQ-030 On that same reset edge, it SHALL drive imem_we=0, core_resetn=0, done=0, error=0, byte_ready=1 (from the next cycle), imem_addr=BASE_ADDR and imem_wdata=0.
REQ-031 Reset asserted mid-load (including during WRITE) SHALL suppress any pending write and discard all partial state.

Structure
REQ-032 Package boot_pkg SHALL hold the state enum (boot_state_t) and the constants BYTE_W=8, WORD_W=32 and LEN_BYTES=2.
REQ-033 One sub-module, word_packer, SHALL hold the byte counter and shift register that assemble 4 bytes into a word and flag word_full.

Verification
REQ-034 Send bytes 01 00 93 00 50 00 C3 -> one write, addr 0x0, data 0x00500093; done=1, and core_resetn=1 the cycle after C3.
REQ-035 Same stream with checksum 00 -> the word is still written, then error=1, core_resetn stays 0 and byte_ready=0.
REQ-036 Send LEN = 0x0101 (257) with MEM_WORDS=256 -> ERROR after LEN_HI, with no imem_we ever asserted.
REQ-037 Send LEN=2 plus 8 data bytes with byte_valid toggling randomly, then the correct checksum -> writes to 0x0 and 0x4 with correct data, then done.
REQ-038 Assert reset after the 2nd data byte, then send the full stream from REQ-034 -> exactly one write, of 0x00500093, then done=1.
REQ-039 Send LEN=0 then checksum 00 -> done=1 with no writes.
